approx_error_sweeper: RTL and testbench
=======================================

Name: approx_error_sweeper

Overview:
- Exhaustive error-evaluation stage downstream of an approximated SOP circuit (e.g. a 4-input abs-diff approximation under error threshold ET).
- Drives every input vector in turn to both the exact and the approximate circuit, and consumes their outputs.
- Accumulates maximum absolute error, error sum and violation count.
- Reports pass/fail against ET when the sweep finishes.

Parameters:
- N_IN, 4, input vector width of the circuit under evaluation; the sweep covers 2^N_IN vectors.
- N_OUT, 3, output width of the exact and approximate circuits; outputs are unsigned integers.
- ET, 3, error threshold; a vector violates when abs error > ET.
- SETTLE, 1, wait cycles after driving a vector before sampling; legal range 1..15.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- in_vec  output  N_IN  registered vector driven to both circuits.
- exact_out  input  N_OUT  exact circuit output for in_vec.
- approx_out  input  N_OUT  approximate circuit output for in_vec.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are final.
- max_err  output  N_OUT  largest abs error seen.
- err_sum  output  N_OUT+N_IN  sum of abs errors; cannot overflow at this width.
- viol_cnt  output  N_IN+1  number of vectors with error > ET.
- pass  output  1  max_err <= ET; valid from done onward.

Behaviour:
- Reset (rst=1 at an edge, wins over everything): state IDLE.
  - in_vec=0, busy=0, done=0, max_err=0, err_sum=0, viol_cnt=0, pass=0, settle counter=0.
  - Reset mid-sweep aborts immediately with no partial results retained.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 -> WAIT, with in_vec<=0, accumulators cleared, pass<=0, busy<=1, settle counter<=SETTLE-1.
  - start=0 -> stay in IDLE; results from the previous sweep are held.
- WAIT:
  - counter>0 -> decrement and stay.
  - counter==0 -> SAMPLE.
  - WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - e = exact_out >= approx_out ? exact_out-approx_out : approx_out-exact_out, computed at N_OUT width with no wrap.
  - max_err <= max(max_err, e).
  - err_sum += e.
  - viol_cnt += (e > ET).
  - If in_vec == 2^N_IN-1 -> DONE.
  - Otherwise in_vec <= in_vec+1, counter <= SETTLE-1 -> WAIT.
- DONE (one cycle):
  - done=1, busy=0; pass <= (max_err <= ET) registered on entry.
  - in_vec holds its last value. Next state IDLE.
- Per-vector period is SETTLE+1 cycles.
- With start sampled at edge 0, done is high in cycle 1 + 2^N_IN*(SETTLE+1).
  - Defaults: cycle 33.
- start while in WAIT, SAMPLE or DONE is ignored.
- start held high continuously restarts a sweep on the IDLE cycle after DONE. Results are cleared at that restart.
- Circuits under evaluation are combinational. Sampled outputs must correspond to in_vec as driven SETTLE+1 cycles earlier.
- ET >= 2^N_OUT-1 means pass is always 1 and viol_cnt is always 0.

Optional Feature:
- Macro ERR_TRACE_EN.
- When defined, adds two outputs:
  - first_viol_vec (N_IN): in_vec of the first violating vector of the sweep.
  - first_viol_valid (1): set in the SAMPLE cycle of that first violation.
- Both are cleared on reset and on sweep start. They hold after done.
- Later violations do not overwrite the capture.
- When undefined: ports and logic are absent, and all other behaviour is identical.

Test Plan:
- approx_out tied to exact_out (exact = a 4-input abs-diff model), start pulse at cycle 0 -> done at cycle 33; max_err=0, err_sum=0, viol_cnt=0, pass=1.
- approx_out = exact_out XOR 3'b100 with exact forced to 0..3 -> every vector e=4; max_err=4, err_sum=64, viol_cnt=16, pass=0.
- approx differs from exact by 3 only at in_vec=5 -> max_err=3, err_sum=3, viol_cnt=0, pass=1 (boundary e == ET is not a violation).
- rst asserted while in_vec=7 -> next cycle: all outputs zero, state IDLE, no done pulse. A new start then gives the same results as an uninterrupted sweep.
- start pulsed again at cycle 10 of a sweep -> ignored, done still at cycle 33. start held high -> second sweep begins the cycle after done, with busy=1 one cycle later.
- ERR_TRACE_EN with violations (e=4) at in_vec=6 and 12 -> first_viol_vec=6, first_viol_valid=1 from the SAMPLE of vector 6; unchanged after vector 12 and after done.

Source files
------------

// File: rtl/approx_error_sweeper.sv
// Exhaustive error sweep of an approximate circuit against its exact reference.
// Optional macro ERR_TRACE_EN adds capture of the first violating input vector.
module approx_error_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int ET     = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       in_vec,
  input  logic [N_OUT-1:0]      exact_out,
  input  logic [N_OUT-1:0]      approx_out,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_OUT+N_IN-1:0] err_sum,
  output logic [N_IN:0]         viol_cnt,
  output logic                  pass
`ifdef ERR_TRACE_EN
  ,
  output logic [N_IN-1:0]       first_viol_vec,
  output logic                  first_viol_valid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam int unsigned ET_U = ET;
  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);

  state_t            state, state_n;
  logic [3:0]        settle_cnt;
  logic [N_OUT-1:0]  abs_err;
  logic [N_OUT-1:0]  max_next;
  logic              viol;
  logic              last_vec;

  always_comb begin
    abs_err  = (exact_out >= approx_out) ? (exact_out - approx_out) : (approx_out - exact_out);
    max_next = (abs_err > max_err) ? abs_err : max_err;
    viol     = (32'(abs_err) > ET_U);
    last_vec = (in_vec == '1);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_WAIT;
      S_WAIT:   if (settle_cnt == '0) state_n = S_SAMPLE;
      S_SAMPLE: state_n = last_vec ? S_DONE : S_WAIT;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_WAIT) || (state == S_SAMPLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_vec     <= '0;
      settle_cnt <= '0;
      max_err    <= '0;
      err_sum    <= '0;
      viol_cnt   <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          in_vec     <= '0;
          settle_cnt <= SETTLE_LD;
          max_err    <= '0;
          err_sum    <= '0;
          viol_cnt   <= '0;
          pass       <= 1'b0;
        end
        S_WAIT: if (settle_cnt != '0) settle_cnt <= settle_cnt - 4'd1;
        S_SAMPLE: begin
          max_err  <= max_next;
          err_sum  <= err_sum + (N_OUT+N_IN)'(abs_err);
          viol_cnt <= viol_cnt + (N_IN+1)'(viol);
          // pass uses the post-sample maximum so it is already valid in the DONE cycle
          if (last_vec) begin
            pass <= (32'(max_next) <= ET_U);
          end else begin
            in_vec     <= in_vec + (N_IN)'(1);
            settle_cnt <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ERR_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      first_viol_vec   <= '0;
      first_viol_valid <= 1'b0;
    end else if (state == S_IDLE && start) begin
      first_viol_vec   <= '0;
      first_viol_valid <= 1'b0;
    end else if (state == S_SAMPLE && viol && !first_viol_valid) begin
      first_viol_vec   <= in_vec;
      first_viol_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Directed bench for approx_error_sweeper: behavioural circuits selected by mode,
// hand-computed sweep results checked with immediate assertions.
module tb_approx_error_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] in_vec;
  logic [2:0] exact_out, approx_out;
  logic       busy, done;
  logic [2:0] max_err;
  logic [6:0] err_sum;
  logic [4:0] viol_cnt;
  logic       pass;
`ifdef ERR_TRACE_EN
  logic [3:0] first_viol_vec;
  logic       first_viol_valid;
`endif

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  logic [2:0] exact_m;

  approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(3), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .exact_out(exact_out), .approx_out(approx_out),
    .busy(busy), .done(done), .max_err(max_err), .err_sum(err_sum),
    .viol_cnt(viol_cnt), .pass(pass)
`ifdef ERR_TRACE_EN
    , .first_viol_vec(first_viol_vec), .first_viol_valid(first_viol_valid)
`endif
  );

  always #5 clk = ~clk;

  // exact: |in_vec[3:2] - in_vec[1:0]|
  always_comb begin
    exact_m = (in_vec[3:2] >= in_vec[1:0]) ? {1'b0, in_vec[3:2] - in_vec[1:0]}
                                           : {1'b0, in_vec[1:0] - in_vec[3:2]};
    exact_out  = exact_m;
    approx_out = exact_m;
    case (mode)
      1: begin exact_out = {1'b0, in_vec[1:0]}; approx_out = {1'b1, in_vec[1:0]}; end
      2: if (in_vec == 4'd5) approx_out = 3'(exact_m + 3'd3);
      3: if (in_vec == 4'd6 || in_vec == 4'd12) approx_out = exact_m ^ 3'b100;
      4: approx_out = 3'd0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start at edge 0; cyc n is the interval after edge n-1
  task automatic sweep(input bit repulse, output int dcyc);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_cycle1", busy, 1);
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      start = repulse && (cyc == 10);
    end
    start = 1'b0;
    dcyc = cyc;
  endtask

  task automatic check_results(input string tag, input int me, input int es, input int vc, input int ps);
    check({tag, "_max_err"}, max_err, me);
    check({tag, "_err_sum"}, err_sum, es);
    check({tag, "_viol_cnt"}, viol_cnt, vc);
    check({tag, "_pass"}, pass, ps);
  endtask

  initial begin
    int dcyc;
    int seen_done;
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_vec", in_vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_results("rst", 0, 0, 0, 0);

    // exact == approx
    mode = 0;
    sweep(1'b0, dcyc);
    check("m0_done_cycle", dcyc, 33);
    check("m0_busy_at_done", busy, 0);
    check("m0_in_vec_last", in_vec, 15);
    check_results("m0", 0, 0, 0, 1);
    tick();
    check("m0_done_pulse", done, 0);

    // every vector e=4, approx above exact
    mode = 1;
    sweep(1'b0, dcyc);
    check("m1_done_cycle", dcyc, 33);
    check_results("m1", 4, 64, 16, 0);
    tick();
    tick();
    tick();
    check("m1_idle_busy", busy, 0);
    check_results("m1_hold", 4, 64, 16, 0);

    // e == ET at a single vector
    mode = 2;
    sweep(1'b1, dcyc);
    check("m2_done_cycle_repulse", dcyc, 33);
    check_results("m2", 3, 3, 0, 1);
    tick();

    // approx below exact: e = exact, sum over all pairs = 20
    mode = 4;
    sweep(1'b0, dcyc);
    check("m4_done_cycle", dcyc, 33);
    check_results("m4", 3, 20, 0, 1);
    tick();

    // reset mid-sweep at vector 7
    start = 1'b1;
    tick();
    start = 1'b0;
    dcyc = 0;
    while (in_vec !== 4'd7 && dcyc < 100) begin
      tick();
      dcyc++;
    end
    check("rst_reach_vec7", in_vec, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_vec", in_vec, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_results("midrst", 0, 0, 0, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("midrst_stays_idle", seen_done, 0);
    sweep(1'b0, dcyc);
    check("after_rst_done_cycle", dcyc, 33);
    check_results("after_rst", 3, 20, 0, 1);
    tick();

    // two violations, trace captures the first
    mode = 3;
    sweep(1'b0, dcyc);
    check("m3_done_cycle", dcyc, 33);
    check_results("m3", 4, 8, 2, 0);
`ifdef ERR_TRACE_EN
    check("m3_first_vec", first_viol_vec, 6);
    check("m3_first_valid", first_viol_valid, 1);
`endif
    tick();
`ifdef ERR_TRACE_EN
    check("m3_first_vec_hold", first_viol_vec, 6);
`endif

    // start held high: restart the cycle after done
    start = 1'b1;
    tick();
    dcyc = 1;
    while (done !== 1'b1 && dcyc < 200) begin
      tick();
      dcyc++;
    end
    check("held_done_cycle", dcyc, 33);
    check_results("held", 4, 8, 2, 0);
    tick();
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    tick();
    check("held_restart_busy", busy, 1);
    check("held_restart_in_vec", in_vec, 0);
    check_results("held_cleared", 0, 0, 0, 0);
`ifdef ERR_TRACE_EN
    check("held_trace_cleared", first_viol_valid, 0);
`endif
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
